mdu_unit: RTL

Multi-cycle multiply/divide unit for the P6 pipelined MIPS core, sitting beside the ALU in the EX stage and owning the HI/LO architectural registers. It generalises the single-cycle ALU datapath to a parametrised operand width, fixed but configurable multiply and divide latencies, and a busy handshake that the hazard unit uses to stall. The unit accepts one operation at a time and commits results to HI/LO atomically when the operation completes.

---
 rtl/mdu_unit.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit owning the HI/LO registers.
// Operations run for a fixed latency (MULT_CYCLES or DIV_CYCLES). HI and LO
// are committed together on the edge that ends the last busy cycle.
// Optional feature macro: MDU_MADD_EN enables madd/maddu/msub/msubu (ops 7-10).
// With the macro undefined those ops are ignored and the accumulate adder is removed.
module mdu_unit #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       mdu_op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int DW      = 2 * WIDTH;
   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MTHI  = 4'd5,
      OP_MTLO  = 4'd6,
      OP_MADD  = 4'd7,
      OP_MADDU = 4'd8,
      OP_MSUB  = 4'd9,
      OP_MSUBU = 4'd10
   } mdu_op_e;

   typedef enum logic {
      S_IDLE,
      S_RUN
   } state_e;

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [3:0]       op_q;

   logic             is_long;
   logic             is_div;
   logic [WIDTH-1:0] hi_d, lo_d;

   logic [DW-1:0]    prod_s, prod_u;
   logic             div_signed;
   logic [WIDTH-1:0] mag_a, mag_b, mag_b_safe;
   logic [WIDTH-1:0] q_mag, r_mag;
   logic             neg_q, neg_r;

   assign busy = busy_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

   // Decode which incoming ops launch a multi-cycle run and which latency applies.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
      is_long = 1'b0;
      is_div  = 1'b0;
      case (mdu_op)
         OP_MULT, OP_MULTU: is_long = 1'b1;
         OP_DIV, OP_DIVU: begin
            is_long = 1'b1;
            is_div  = 1'b1;
         end
`ifdef MDU_MADD_EN
         OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_long = 1'b1;
`endif
         default: ;
      endcase
   end

   // Compute the final HI/LO values from the captured operands and current HI/LO.
   always_comb begin
      prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
      prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

      // Signed divide works on magnitudes; the most-negative / -1 case falls out
      // naturally as quotient = most-negative, remainder = 0.
      div_signed = (op_q == OP_DIV);
      mag_a      = (div_signed && a_q[WIDTH-1]) ? -a_q : a_q;
      mag_b      = (div_signed && b_q[WIDTH-1]) ? -b_q : b_q;
      mag_b_safe = (mag_b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
      q_mag      = mag_a / mag_b_safe;
      r_mag      = mag_a % mag_b_safe;
      neg_q      = div_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
      neg_r      = div_signed && a_q[WIDTH-1];

      hi_d = hi_q;
      lo_d = lo_q;
      case (op_q)
         OP_MULT:  {hi_d, lo_d} = prod_s;
         OP_MULTU: {hi_d, lo_d} = prod_u;
         OP_DIV, OP_DIVU: begin
            if (b_q == '0) begin
               lo_d = '1;
               hi_d = a_q;
            end else begin
               lo_d = neg_q ? -q_mag : q_mag;
               hi_d = neg_r ? -r_mag : r_mag;
            end
         end
`ifdef MDU_MADD_EN
         OP_MADD:  {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
         OP_MADDU: {hi_d, lo_d} = {hi_q, lo_q} + prod_u;
         OP_MSUB:  {hi_d, lo_d} = {hi_q, lo_q} - prod_s;
         OP_MSUBU: {hi_d, lo_d} = {hi_q, lo_q} - prod_u;
`endif
         default: ;
      endcase
   end

   // Control FSM: accept ops in IDLE, count down latency in RUN, commit HI/LO atomically.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= OP_NONE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  if (mdu_op == OP_MTHI) begin
                     hi_q <= src_a;
                  end else if (mdu_op == OP_MTLO) begin
                     lo_q <= src_a;
                  end else if (is_long) begin
                     a_q     <= src_a;
                     b_q     <= src_b;
                     op_q    <= mdu_op;
                     cnt_q   <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                     busy_q  <= 1'b1;
                     state_q <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (cnt_q == CNT_W'(1)) begin
                  hi_q    <= hi_d;
                  lo_q    <= lo_d;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule
